// File: rtl/id_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_reg_pkg
// Shared widths and types for the ID/EX pipeline register.
//   - Data, register-address, ALU-command and immediate widths used by the
//     register file and the decode stage.
//   - id_ex_t: the bundle of fields captured from decode into execute.
//   - stage_action_e / decode_action(): per-edge action selection.
// -----------------------------------------------------------------------------
package id_stage_reg_pkg;

    localparam int DATA_W       = 32;
    localparam int REG_ADDR_W   = 4;
    localparam int EXE_CMD_W    = 4;
    localparam int SHIFT_OP_W   = 12;
    localparam int SIMM24_W     = 24;
    localparam int STATUS_W     = 4;
    localparam int BUBBLE_CNT_W = 16;

    localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_CNT_MAX = '1;

    typedef struct packed {
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     reg1;
        logic [DATA_W-1:0]     reg2;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
        logic [REG_ADDR_W-1:0] dest;
        logic [EXE_CMD_W-1:0]  exe_cmd;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic                  wb_en;
        logic                  b;
        logic                  s;
        logic                  imm;
        logic [SHIFT_OP_W-1:0] shift_operand;
        logic [SIMM24_W-1:0]   signed_imm_24;
        logic [STATUS_W-1:0]   status;
        logic                  valid;
    } id_ex_t;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_LOAD
    } stage_action_e;

    // Strict priority: reset, then flush (wins over a memory stall so a taken
    // branch is never lost), then freeze, then hazard, then a normal load.
    function automatic stage_action_e decode_action(input logic rst,
                                                    input logic flush,
                                                    input logic freeze,
                                                    input logic hazard);
        if (rst)         return ACT_RESET;
        else if (flush)  return ACT_FLUSH;
        else if (freeze) return ACT_HOLD;
        else if (hazard) return ACT_BUBBLE;
        else             return ACT_LOAD;
    endfunction

endpackage

// File: rtl/id_stage_reg_bypass_mux.sv
// -----------------------------------------------------------------------------
// id_bypass_mux
// Same-cycle write-back bypass for one source operand: when the write-back
// stage is writing the register this operand reads, take the write-back
// result instead of the (stale) register-file read data.
// Ports:
//   i_src       register address read by this operand
//   i_reg_data  register-file read data for i_src
//   i_wb_en_wb  write-back stage write enable
//   i_dest_wb   write-back destination register
//   i_result_wb write-back data
//   o_data      operand value to capture
// -----------------------------------------------------------------------------
module id_bypass_mux
    import id_stage_reg_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic [DATA_W-1:0]     i_reg_data,
    input  logic                  i_wb_en_wb,
    input  logic [REG_ADDR_W-1:0] i_dest_wb,
    input  logic [DATA_W-1:0]     i_result_wb,
    output logic [DATA_W-1:0]     o_data
);

    logic w_hit;

    assign w_hit  = i_wb_en_wb && (i_dest_wb == i_src);
    assign o_data = w_hit ? i_result_wb : i_reg_data;

endmodule

// File: rtl/id_stage_reg.sv
// -----------------------------------------------------------------------------
// id_stage_reg
// ID/EX pipeline register. Captures the decoded instruction each cycle with
// flush (squash), freeze (hold everything) and hazard (insert a bubble)
// controls, a same-cycle write-back bypass on both source operands and a
// saturating count of inserted bubbles. All outputs are registered.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush, freeze, hazard         pipeline controls (priority rst>flush>freeze>hazard)
//   *_in                          decoded instruction fields
//   wb_en_wb, dest_wb, result_wb  write-back bypass source
//   *_out, valid_out              registered instruction fields
//   bubble_cnt                    number of hazard bubbles inserted (saturating)
// -----------------------------------------------------------------------------
module id_stage_reg
    import id_stage_reg_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    freeze,
    input  logic                    hazard,
    input  logic [DATA_W-1:0]       pc_in,
    input  logic [DATA_W-1:0]       reg1_in,
    input  logic [DATA_W-1:0]       reg2_in,
    input  logic [REG_ADDR_W-1:0]   src1_in,
    input  logic [REG_ADDR_W-1:0]   src2_in,
    input  logic [REG_ADDR_W-1:0]   dest_in,
    input  logic [EXE_CMD_W-1:0]    exe_cmd_in,
    input  logic                    mem_r_en_in,
    input  logic                    mem_w_en_in,
    input  logic                    wb_en_in,
    input  logic                    b_in,
    input  logic                    s_in,
    input  logic                    imm_in,
    input  logic [SHIFT_OP_W-1:0]   shift_operand_in,
    input  logic [SIMM24_W-1:0]     signed_imm_24_in,
    input  logic [STATUS_W-1:0]     status_in,
    input  logic                    wb_en_wb,
    input  logic [REG_ADDR_W-1:0]   dest_wb,
    input  logic [DATA_W-1:0]       result_wb,
    output logic [DATA_W-1:0]       pc_out,
    output logic [DATA_W-1:0]       reg1_out,
    output logic [DATA_W-1:0]       reg2_out,
    output logic [REG_ADDR_W-1:0]   src1_out,
    output logic [REG_ADDR_W-1:0]   src2_out,
    output logic [REG_ADDR_W-1:0]   dest_out,
    output logic [EXE_CMD_W-1:0]    exe_cmd_out,
    output logic                    mem_r_en_out,
    output logic                    mem_w_en_out,
    output logic                    wb_en_out,
    output logic                    b_out,
    output logic                    s_out,
    output logic                    imm_out,
    output logic [SHIFT_OP_W-1:0]   shift_operand_out,
    output logic [SIMM24_W-1:0]     signed_imm_24_out,
    output logic [STATUS_W-1:0]     status_out,
    output logic                    valid_out,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

    id_ex_t                  r_stage;
    logic [BUBBLE_CNT_W-1:0] r_bubble_cnt;

    logic [DATA_W-1:0] w_reg1;
    logic [DATA_W-1:0] w_reg2;
    id_ex_t            w_load;
    id_ex_t            w_bubble;
    stage_action_e     w_action;

    id_bypass_mux u_bypass_src1 (
        .i_src       (src1_in),
        .i_reg_data  (reg1_in),
        .i_wb_en_wb  (wb_en_wb),
        .i_dest_wb   (dest_wb),
        .i_result_wb (result_wb),
        .o_data      (w_reg1)
    );

    id_bypass_mux u_bypass_src2 (
        .i_src       (src2_in),
        .i_reg_data  (reg2_in),
        .i_wb_en_wb  (wb_en_wb),
        .i_dest_wb   (dest_wb),
        .i_result_wb (result_wb),
        .o_data      (w_reg2)
    );

    assign w_action = decode_action(rst, flush, freeze, hazard);

    assign w_load = '{
        pc:            pc_in,
        reg1:          w_reg1,
        reg2:          w_reg2,
        src1:          src1_in,
        src2:          src2_in,
        dest:          dest_in,
        exe_cmd:       exe_cmd_in,
        mem_r_en:      mem_r_en_in,
        mem_w_en:      mem_w_en_in,
        wb_en:         wb_en_in,
        b:             b_in,
        s:             s_in,
        imm:           imm_in,
        shift_operand: shift_operand_in,
        signed_imm_24: signed_imm_24_in,
        status:        status_in,
        valid:         1'b1
    };

    // A bubble still carries the operand data forward; only the bits that
    // cause architectural side effects are cleared.
    always_comb begin
        w_bubble          = w_load;
        w_bubble.mem_r_en = 1'b0;
        w_bubble.mem_w_en = 1'b0;
        w_bubble.wb_en    = 1'b0;
        w_bubble.b        = 1'b0;
        w_bubble.s        = 1'b0;
        w_bubble.valid    = 1'b0;
    end

    // NOTE: every register here uses non-blocking assignment so all fields
    // update together from pre-edge values; blocking would create ordering races.
    always_ff @(posedge clk) begin
        unique case (w_action)
            ACT_RESET: begin
                r_stage      <= '0;
                r_bubble_cnt <= '0;
            end
            // The bubble counter is a statistic, not part of the squashed
            // instruction, so a flush leaves it alone.
            ACT_FLUSH: r_stage <= '0;
            ACT_HOLD:  ;
            ACT_BUBBLE: begin
                r_stage <= w_bubble;
                if (r_bubble_cnt != BUBBLE_CNT_MAX)
                    r_bubble_cnt <= r_bubble_cnt + BUBBLE_CNT_W'(1);
            end
            ACT_LOAD:  r_stage <= w_load;
            default:   ;
        endcase
    end

    assign pc_out            = r_stage.pc;
    assign reg1_out          = r_stage.reg1;
    assign reg2_out          = r_stage.reg2;
    assign src1_out          = r_stage.src1;
    assign src2_out          = r_stage.src2;
    assign dest_out          = r_stage.dest;
    assign exe_cmd_out       = r_stage.exe_cmd;
    assign mem_r_en_out      = r_stage.mem_r_en;
    assign mem_w_en_out      = r_stage.mem_w_en;
    assign wb_en_out         = r_stage.wb_en;
    assign b_out             = r_stage.b;
    assign s_out             = r_stage.s;
    assign imm_out           = r_stage.imm;
    assign shift_operand_out = r_stage.shift_operand;
    assign signed_imm_24_out = r_stage.signed_imm_24;
    assign status_out        = r_stage.status;
    assign valid_out         = r_stage.valid;
    assign bubble_cnt        = r_bubble_cnt;

endmodule

// File: tb/tb_id_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_stage_reg
// Self-checking bench for id_stage_reg: directed scenarios followed by a
// random phase, all compared against a behavioural model of the stage.
// -----------------------------------------------------------------------------
module tb_id_stage_reg;
    import id_stage_reg_pkg::*;

    logic clk = 1'b0;
    logic rst, flush, freeze, hazard;
    logic [DATA_W-1:0]     pc_in, reg1_in, reg2_in, result_wb;
    logic [REG_ADDR_W-1:0] src1_in, src2_in, dest_in, dest_wb;
    logic [EXE_CMD_W-1:0]  exe_cmd_in;
    logic mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in, wb_en_wb;
    logic [SHIFT_OP_W-1:0] shift_operand_in;
    logic [SIMM24_W-1:0]   signed_imm_24_in;
    logic [STATUS_W-1:0]   status_in;

    logic [DATA_W-1:0]       pc_out, reg1_out, reg2_out;
    logic [REG_ADDR_W-1:0]   src1_out, src2_out, dest_out;
    logic [EXE_CMD_W-1:0]    exe_cmd_out;
    logic mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out, valid_out;
    logic [SHIFT_OP_W-1:0]   shift_operand_out;
    logic [SIMM24_W-1:0]     signed_imm_24_out;
    logic [STATUS_W-1:0]     status_out;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .hazard(hazard),
        .pc_in(pc_in), .reg1_in(reg1_in), .reg2_in(reg2_in),
        .src1_in(src1_in), .src2_in(src2_in), .dest_in(dest_in),
        .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .wb_en_in(wb_en_in), .b_in(b_in), .s_in(s_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .status_in(status_in), .wb_en_wb(wb_en_wb), .dest_wb(dest_wb), .result_wb(result_wb),
        .pc_out(pc_out), .reg1_out(reg1_out), .reg2_out(reg2_out),
        .src1_out(src1_out), .src2_out(src2_out), .dest_out(dest_out),
        .exe_cmd_out(exe_cmd_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .wb_en_out(wb_en_out), .b_out(b_out), .s_out(s_out), .imm_out(imm_out),
        .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
        .status_out(status_out), .valid_out(valid_out), .bubble_cnt(bubble_cnt)
    );

    // Behavioural model of what the outputs should hold.
    typedef struct {
        longint pc, reg1, reg2, src1, src2, dest, exe_cmd;
        longint mem_r, mem_w, wb, b, s, imm, shift, simm24, status, valid, cnt;
    } model_t;

    model_t m;

    function automatic model_t model_zero(input longint cnt);
        model_t z;
        z = '{default: 0};
        z.cnt = cnt;
        return z;
    endfunction

    // Next model state from the rules of the stage, given the current inputs.
    function automatic model_t model_next(input model_t cur);
        model_t n;
        n = cur;
        if (rst) begin
            n = model_zero(0);
        end else if (flush) begin
            n = model_zero(cur.cnt);
        end else if (!freeze) begin
            n.pc      = pc_in;
            n.reg1    = (wb_en_wb && dest_wb == src1_in) ? result_wb : reg1_in;
            n.reg2    = (wb_en_wb && dest_wb == src2_in) ? result_wb : reg2_in;
            n.src1    = src1_in;
            n.src2    = src2_in;
            n.dest    = dest_in;
            n.exe_cmd = exe_cmd_in;
            n.imm     = imm_in;
            n.shift   = shift_operand_in;
            n.simm24  = signed_imm_24_in;
            n.status  = status_in;
            if (hazard) begin
                n.mem_r = 0; n.mem_w = 0; n.wb = 0; n.b = 0; n.s = 0; n.valid = 0;
                n.cnt   = (cur.cnt < 65535) ? cur.cnt + 1 : 65535;
            end else begin
                n.mem_r = mem_r_en_in; n.mem_w = mem_w_en_in; n.wb = wb_en_in;
                n.b = b_in; n.s = s_in; n.valid = 1;
            end
        end
        return n;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("pc_out",            longint'(pc_out),            m.pc);
        check("reg1_out",          longint'(reg1_out),          m.reg1);
        check("reg2_out",          longint'(reg2_out),          m.reg2);
        check("src1_out",          longint'(src1_out),          m.src1);
        check("src2_out",          longint'(src2_out),          m.src2);
        check("dest_out",          longint'(dest_out),          m.dest);
        check("exe_cmd_out",       longint'(exe_cmd_out),       m.exe_cmd);
        check("mem_r_en_out",      longint'(mem_r_en_out),      m.mem_r);
        check("mem_w_en_out",      longint'(mem_w_en_out),      m.mem_w);
        check("wb_en_out",         longint'(wb_en_out),         m.wb);
        check("b_out",             longint'(b_out),             m.b);
        check("s_out",             longint'(s_out),             m.s);
        check("imm_out",           longint'(imm_out),           m.imm);
        check("shift_operand_out", longint'(shift_operand_out), m.shift);
        check("signed_imm_24_out", longint'(signed_imm_24_out), m.simm24);
        check("status_out",        longint'(status_out),        m.status);
        check("valid_out",         longint'(valid_out),         m.valid);
        check("bubble_cnt",        longint'(bubble_cnt),        m.cnt);
    endtask

    // One clock: model advances with the inputs seen at the edge, outputs are
    // sampled 1 time unit after the edge.
    task automatic tick(input bit do_check);
        model_t n;
        n = model_next(m);
        @(posedge clk);
        #1;
        m = n;
        if (do_check) check_all();
    endtask

    task automatic clear_inputs();
        rst = 0; flush = 0; freeze = 0; hazard = 0;
        pc_in = '0; reg1_in = '0; reg2_in = '0; result_wb = '0;
        src1_in = '0; src2_in = '0; dest_in = '0; dest_wb = '0;
        exe_cmd_in = '0; mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0;
        b_in = 0; s_in = 0; imm_in = 0; wb_en_wb = 0;
        shift_operand_in = '0; signed_imm_24_in = '0; status_in = '0;
    endtask

    task automatic rand_data();
        pc_in            = $urandom;
        reg1_in          = $urandom;
        reg2_in          = $urandom;
        result_wb        = $urandom;
        src1_in          = REG_ADDR_W'($urandom_range(0, 3));
        src2_in          = REG_ADDR_W'($urandom_range(0, 3));
        dest_wb          = REG_ADDR_W'($urandom_range(0, 3));
        dest_in          = REG_ADDR_W'($urandom);
        exe_cmd_in       = EXE_CMD_W'($urandom);
        mem_r_en_in      = 1'($urandom);
        mem_w_en_in      = 1'($urandom);
        wb_en_in         = 1'($urandom);
        b_in             = 1'($urandom);
        s_in             = 1'($urandom);
        imm_in           = 1'($urandom);
        wb_en_wb         = 1'($urandom);
        shift_operand_in = SHIFT_OP_W'($urandom);
        signed_imm_24_in = SIMM24_W'($urandom);
        status_in        = STATUS_W'($urandom);
    endtask

    initial begin
        m = model_zero(0);
        clear_inputs();

        // Reset state
        rst = 1; flush = 1; hazard = 1;
        tick(1);
        check("rst_valid", longint'(valid_out), 0);
        check("rst_bubble", longint'(bubble_cnt), 0);

        // Plain load
        clear_inputs();
        pc_in = 32'h10; reg1_in = 5; reg2_in = 7; wb_en_in = 1;
        tick(1);
        check("load_pc", longint'(pc_out), 'h10);
        check("load_reg1", longint'(reg1_out), 5);
        check("load_reg2", longint'(reg2_out), 7);
        check("load_wb_en", longint'(wb_en_out), 1);
        check("load_valid", longint'(valid_out), 1);

        // Bypass on src1, then with write-back disabled
        clear_inputs();
        src1_in = 3; reg1_in = 32'hAAAA; wb_en_wb = 1; dest_wb = 3; result_wb = 32'h1234;
        tick(1);
        check("byp_on_reg1", longint'(reg1_out), 'h1234);
        wb_en_wb = 0;
        tick(1);
        check("byp_off_reg1", longint'(reg1_out), 'hAAAA);

        // Bypass on both sources reading the same register
        src1_in = 6; src2_in = 6; reg1_in = 1; reg2_in = 2;
        wb_en_wb = 1; dest_wb = 6; result_wb = 32'hBEEF;
        tick(1);
        check("byp_both_reg1", longint'(reg1_out), 'hBEEF);
        check("byp_both_reg2", longint'(reg2_out), 'hBEEF);

        // Freeze for three cycles with changing inputs, then flush under freeze
        clear_inputs();
        pc_in = 32'h44; wb_en_in = 1;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            rand_data();
            freeze = 1;
            tick(1);
            check("freeze_pc", longint'(pc_out), 'h44);
            check("freeze_valid", longint'(valid_out), 1);
        end
        flush = 1; freeze = 1;
        tick(1);
        check("flush_pc", longint'(pc_out), 0);
        check("flush_valid", longint'(valid_out), 0);

        // Hazard bubble, then hazard under freeze
        clear_inputs();
        hazard = 1; mem_w_en_in = 1; reg2_in = 9; wb_en_in = 1;
        tick(1);
        check("haz_mem_w", longint'(mem_w_en_out), 0);
        check("haz_reg2", longint'(reg2_out), 9);
        check("haz_valid", longint'(valid_out), 0);
        check("haz_cnt", longint'(bubble_cnt), 1);
        freeze = 1;
        tick(1);
        check("haz_frz_cnt", longint'(bubble_cnt), 1);

        // Random phase
        for (int i = 0; i < 800; i++) begin
            rand_data();
            rst    = ($urandom_range(0, 49) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            freeze = ($urandom_range(0, 3) == 0);
            hazard = ($urandom_range(0, 3) == 0);
            tick(1);
        end

        // Reset beats every other control, then a clean load
        rand_data();
        rst = 1; flush = 1; freeze = 1; hazard = 1;
        tick(1);
        check("rst_all_valid", longint'(valid_out), 0);
        check("rst_all_cnt", longint'(bubble_cnt), 0);
        clear_inputs();
        pc_in = 32'h20; wb_en_in = 1;
        tick(1);
        check("post_rst_pc", longint'(pc_out), 'h20);
        check("post_rst_valid", longint'(valid_out), 1);

        // Reset in the middle of a stall
        freeze = 1; pc_in = 32'h30;
        tick(1);
        rst = 1;
        tick(1);
        check("rst_stall_pc", longint'(pc_out), 0);
        rst = 0;
        tick(1);
        check("stall_after_rst_valid", longint'(valid_out), 0);
        freeze = 0; pc_in = 32'h88;
        tick(1);
        check("unstall_pc", longint'(pc_out), 'h88);
        check("unstall_valid", longint'(valid_out), 1);

        // Saturation of the bubble counter
        rst = 1;
        tick(1);
        clear_inputs();
        hazard = 1;
        repeat (65535) tick(0);
        check("sat_reach", longint'(bubble_cnt), 'hFFFF);
        tick(1);
        check("sat_hold", longint'(bubble_cnt), 'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
